// File: rtl/program_memory_if.sv
// -----------------------------------------------------------------------------
// program_memory_if
// Bus bundle between the accumulator CPU / image loader (master side) and the
// unified program/data memory (slave side).
//
// CPU port : cpu_address, cpu_data_out, cpu_mem_write  (master -> memory)
//            cpu_data_in, cpu_rst_n                    (memory -> master)
// Loader   : ld_start, ld_valid, ld_data, ld_last      (master -> memory)
//            ld_ready, ld_done, ld_count               (memory -> master)
// -----------------------------------------------------------------------------
interface program_memory_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] cpu_address;
    logic [DATA_W-1:0] cpu_data_out;
    logic              cpu_mem_write;
    logic [DATA_W-1:0] cpu_data_in;
    logic              cpu_rst_n;

    logic              ld_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              ld_done;
    logic [ADDR_W:0]   ld_count;

    modport master (
        output cpu_address, cpu_data_out, cpu_mem_write,
        output ld_start, ld_valid, ld_data, ld_last,
        input  cpu_data_in, cpu_rst_n,
        input  ld_ready, ld_done, ld_count
    );

    modport slave (
        input  cpu_address, cpu_data_out, cpu_mem_write,
        input  ld_start, ld_valid, ld_data, ld_last,
        output cpu_data_in, cpu_rst_n,
        output ld_ready, ld_done, ld_count
    );
endinterface

// File: rtl/program_memory.sv
// -----------------------------------------------------------------------------
// program_memory
// Unified 2^ADDR_W x DATA_W program/data memory for the accumulator CPU, with
// a streaming loader that zero-fills the array, writes a program image and
// keeps the CPU in reset until the image is complete.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - program_memory_if.slave (CPU port + loader port)
//
// state   | meaning
// --------+---------------------------------------------------------------
// HOLD    | CPU held in reset, waiting for ld_start
// CLEAR   | writing zero to every address, one per cycle
// LOAD    | accepting loader words (ld_ready=1)
// RELEASE | one-cycle gap before the CPU is let go
// RUN     | CPU owns the memory; ld_start restarts the load sequence
// -----------------------------------------------------------------------------
module program_memory #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    program_memory_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        S_HOLD,
        S_CLEAR,
        S_LOAD,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_cpu_rst_n;
    logic              r_ld_ready;
    logic              r_ld_done;
    logic [DATA_W-1:0] r_data_in;

    // Array is intentionally not reset; contents survive rst_n.
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_ptr_end;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    assign w_accept  = (r_state == S_LOAD) && bus.ld_valid && r_ld_ready;
    assign w_ptr_end = (r_ptr == LAST_ADDR);

    // Single write port shared by the clear sweep, the loader and the CPU.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_ptr;
        w_wdata = '0;
        case (r_state)
            S_CLEAR: begin
                w_we = 1'b1;
            end
            S_LOAD: begin
                w_we    = w_accept;
                w_wdata = bus.ld_data;
            end
            S_RUN: begin
                w_we    = bus.cpu_mem_write;
                w_waddr = bus.cpu_address;
                w_wdata = bus.cpu_data_out;
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_HOLD;
            r_ptr       <= '0;
            r_count     <= '0;
            r_cpu_rst_n <= 1'b0;
            r_ld_ready  <= 1'b0;
            r_ld_done   <= 1'b0;
            r_data_in   <= '0;
        end else begin
            r_ld_done <= 1'b0;
            r_data_in <= '0;
            case (r_state)
                S_HOLD: begin
                    if (bus.ld_start) begin
                        r_state <= S_CLEAR;
                        r_ptr   <= '0;
                    end
                end
                S_CLEAR: begin
                    if (w_ptr_end) begin
                        r_state    <= S_LOAD;
                        r_ptr      <= '0;
                        r_count    <= '0;
                        r_ld_ready <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_count <= r_count + 1'b1;
                        // Pointer parks at the top address instead of wrapping.
                        if (!w_ptr_end) begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                        if (bus.ld_last || w_ptr_end) begin
                            r_state    <= S_RELEASE;
                            r_ld_ready <= 1'b0;
                        end
                    end
                end
                S_RELEASE: begin
                    r_state     <= S_RUN;
                    r_cpu_rst_n <= 1'b1;
                    r_ld_done   <= 1'b1;
                end
                S_RUN: begin
                    // Read-first: the array write on this edge is not yet
                    // visible, so a same-address read returns the old word.
                    r_data_in <= r_mem[bus.cpu_address];
                    if (bus.ld_start) begin
                        r_state     <= S_CLEAR;
                        r_ptr       <= '0;
                        r_cpu_rst_n <= 1'b0;
                        r_data_in   <= '0;
                    end
                end
                default: begin
                    r_state <= S_HOLD;
                end
            endcase
        end
    end

    assign bus.cpu_data_in = r_data_in;
    assign bus.cpu_rst_n   = r_cpu_rst_n;
    assign bus.ld_ready    = r_ld_ready;
    assign bus.ld_done     = r_ld_done;
    assign bus.ld_count    = r_count;

endmodule

// File: tb/tb_program_memory.sv
// -----------------------------------------------------------------------------
// tb_program_memory
// Randomized self-checking bench for program_memory. The expected memory image
// is kept as a plain array: a load zeroes it and copies the image words in,
// CPU writes update it after the same-cycle read has been predicted.
// -----------------------------------------------------------------------------
module tb_program_memory;
    logic clk;
    logic rst_n;

    program_memory_if #(.DATA_W(16), .ADDR_W(8)) pm_if ();

    program_memory #(.DATA_W(16), .ADDR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (pm_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_err;
    logic [15:0] ref_mem  [256];
    logic [15:0] ld_words [256];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request a load and measure the clear sweep length.
    task automatic start_load();
        int lat;
        pm_if.ld_start = 1'b1;
        tick();
        pm_if.ld_start = 1'b0;
        n_cmp++;
        if (pm_if.cpu_rst_n !== 1'b0) begin
            n_err++;
            $display("FAIL start_cpu_rst_n: got %b expected 0", pm_if.cpu_rst_n);
        end
        n_cmp++;
        if (pm_if.cpu_data_in !== 16'h0000) begin
            n_err++;
            $display("FAIL start_data_in: got %h expected 0000", pm_if.cpu_data_in);
        end
        lat = 0;
        while (lat < 300) begin
            pm_if.ld_start      = 1'($urandom_range(0, 1));
            pm_if.cpu_mem_write = 1'($urandom_range(0, 1));
            pm_if.cpu_address   = 8'($urandom);
            pm_if.cpu_data_out  = 16'($urandom);
            tick();
            lat++;
            if (pm_if.ld_ready === 1'b1) break;
        end
        pm_if.ld_start      = 1'b0;
        pm_if.cpu_mem_write = 1'b0;
        n_cmp++;
        if (lat !== 256) begin
            n_err++;
            $display("FAIL clear_latency: got %0d cycles expected 256", lat);
        end
    endtask

    // Stream n words from ld_words with random gaps and random ignored inputs.
    task automatic stream(input int n, input bit use_last, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                pm_if.ld_valid      = 1'b0;
                pm_if.ld_last       = 1'($urandom_range(0, 1));
                pm_if.ld_data       = 16'($urandom);
                pm_if.ld_start      = 1'($urandom_range(0, 1));
                pm_if.cpu_mem_write = 1'($urandom_range(0, 1));
                pm_if.cpu_address   = 8'($urandom);
                tick();
            end
            n_cmp++;
            if (pm_if.ld_ready !== 1'b1) begin
                n_err++;
                $display("FAIL ld_ready_in_load: word %0d got %b expected 1", i, pm_if.ld_ready);
            end
            pm_if.ld_valid      = 1'b1;
            pm_if.ld_data       = ld_words[i];
            pm_if.ld_last       = use_last && (i == n - 1);
            pm_if.ld_start      = 1'($urandom_range(0, 1));
            pm_if.cpu_mem_write = 1'($urandom_range(0, 1));
            pm_if.cpu_address   = 8'($urandom);
            tick();
        end
        pm_if.ld_valid      = 1'b0;
        pm_if.ld_last       = 1'b0;
        pm_if.ld_start      = 1'b0;
        pm_if.cpu_mem_write = 1'b0;
    endtask

    // Called right after the final accepting edge; checks the release sequence.
    task automatic check_release(input int n);
        n_cmp++;
        if (pm_if.ld_ready !== 1'b0 || pm_if.cpu_rst_n !== 1'b0 || pm_if.ld_done !== 1'b0) begin
            n_err++;
            $display("FAIL release_cycle: got ready=%b cpu_rst_n=%b done=%b expected 0/0/0",
                     pm_if.ld_ready, pm_if.cpu_rst_n, pm_if.ld_done);
        end
        tick();
        n_cmp++;
        if (pm_if.cpu_rst_n !== 1'b1 || pm_if.ld_done !== 1'b1) begin
            n_err++;
            $display("FAIL run_entry: got cpu_rst_n=%b done=%b expected 1/1",
                     pm_if.cpu_rst_n, pm_if.ld_done);
        end
        n_cmp++;
        if (pm_if.ld_count !== 9'(n)) begin
            n_err++;
            $display("FAIL ld_count: got %0d expected %0d", pm_if.ld_count, n);
        end
        tick();
        n_cmp++;
        if (pm_if.ld_done !== 1'b0 || pm_if.ld_count !== 9'(n) || pm_if.cpu_rst_n !== 1'b1) begin
            n_err++;
            $display("FAIL done_pulse: got done=%b count=%0d cpu_rst_n=%b expected 0/%0d/1",
                     pm_if.ld_done, pm_if.ld_count, pm_if.cpu_rst_n, n);
        end
        for (int a = 0; a < 256; a++) ref_mem[a] = 16'h0000;
        for (int a = 0; a < n; a++) ref_mem[a] = ld_words[a];
    endtask

    task automatic test_reset();
        pm_if.cpu_address   = '0;
        pm_if.cpu_data_out  = '0;
        pm_if.cpu_mem_write = 1'b0;
        pm_if.ld_start      = 1'b0;
        pm_if.ld_valid      = 1'b0;
        pm_if.ld_data       = '0;
        pm_if.ld_last       = 1'b0;
        rst_n = 1'b0;
        #3;
        n_cmp++;
        if (pm_if.cpu_rst_n !== 1'b0 || pm_if.cpu_data_in !== 16'h0 || pm_if.ld_ready !== 1'b0 ||
            pm_if.ld_done !== 1'b0 || pm_if.ld_count !== 9'd0) begin
            n_err++;
            $display("FAIL reset_values: got rst=%b din=%h rdy=%b done=%b cnt=%0d expected all 0",
                     pm_if.cpu_rst_n, pm_if.cpu_data_in, pm_if.ld_ready, pm_if.ld_done, pm_if.ld_count);
        end
        #9 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pm_if.cpu_address   = 8'($urandom);
            pm_if.cpu_data_out  = 16'($urandom);
            pm_if.cpu_mem_write = 1'($urandom_range(0, 1));
            tick();
            n_cmp++;
            if (pm_if.cpu_rst_n !== 1'b0 || pm_if.ld_ready !== 1'b0 || pm_if.cpu_data_in !== 16'h0) begin
                n_err++;
                $display("FAIL hold_idle: cycle %0d got rst=%b rdy=%b din=%h expected 0/0/0000",
                         i, pm_if.cpu_rst_n, pm_if.ld_ready, pm_if.cpu_data_in);
            end
        end
        pm_if.cpu_mem_write = 1'b0;
    endtask

    task automatic test_basic_load();
        int addrs [8];
        ld_words[0] = 16'h0232;
        ld_words[1] = 16'h0164;
        ld_words[2] = 16'h0700;
        start_load();
        stream(3, 1'b1, 30);
        check_release(3);
        addrs = '{1, 3, 255, 0, 2, 4, 128, 254};
        foreach (addrs[k]) begin
            pm_if.cpu_address = 8'(addrs[k]);
            tick();
            n_cmp++;
            if (pm_if.cpu_data_in !== ref_mem[addrs[k]]) begin
                n_err++;
                $display("FAIL basic_read: addr %0d got %h expected %h",
                         addrs[k], pm_if.cpu_data_in, ref_mem[addrs[k]]);
            end
        end
    endtask

    task automatic test_read_first();
        logic [15:0] exp;
        logic [7:0]  a;
        logic [15:0] d;
        logic        we;
        pm_if.cpu_address   = 8'd100;
        pm_if.cpu_data_out  = 16'h00FF;
        pm_if.cpu_mem_write = 1'b1;
        exp = ref_mem[100];
        ref_mem[100] = 16'h00FF;
        tick();
        n_cmp++;
        if (pm_if.cpu_data_in !== exp) begin
            n_err++;
            $display("FAIL read_first_old: got %h expected %h", pm_if.cpu_data_in, exp);
        end
        pm_if.cpu_mem_write = 1'b0;
        tick();
        n_cmp++;
        if (pm_if.cpu_data_in !== 16'h00FF) begin
            n_err++;
            $display("FAIL read_first_new: got %h expected 00ff", pm_if.cpu_data_in);
        end
        // Random CPU traffic biased toward a small address window for collisions.
        for (int i = 0; i < 60; i++) begin
            a  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(250, 255)) : 8'($urandom);
            d  = 16'($urandom);
            we = 1'($urandom_range(0, 1));
            pm_if.cpu_address   = a;
            pm_if.cpu_data_out  = d;
            pm_if.cpu_mem_write = we;
            exp = ref_mem[a];
            if (we) ref_mem[a] = d;
            tick();
            n_cmp++;
            if (pm_if.cpu_data_in !== exp) begin
                n_err++;
                $display("FAIL cpu_random: addr %0d got %h expected %h", a, pm_if.cpu_data_in, exp);
            end
        end
        pm_if.cpu_mem_write = 1'b0;
    endtask

    task automatic test_full_load();
        for (int i = 0; i < 256; i++) ld_words[i] = 16'(i) ^ 16'hA5A5;
        start_load();
        stream(256, 1'b0, 35);
        check_release(256);
        for (int a = 0; a < 256; a++) begin
            pm_if.cpu_address = 8'(a);
            tick();
            n_cmp++;
            if (pm_if.cpu_data_in !== ref_mem[a]) begin
                n_err++;
                $display("FAIL full_readback: addr %0d got %h expected %h",
                         a, pm_if.cpu_data_in, ref_mem[a]);
            end
        end
    endtask

    task automatic test_reload();
        pm_if.cpu_address   = 8'd60;
        pm_if.cpu_data_out  = 16'h1234;
        pm_if.cpu_mem_write = 1'b1;
        tick();
        ref_mem[60] = 16'h1234;
        pm_if.cpu_mem_write = 1'b0;
        tick();
        n_cmp++;
        if (pm_if.cpu_data_in !== 16'h1234) begin
            n_err++;
            $display("FAIL reload_prewrite: got %h expected 1234", pm_if.cpu_data_in);
        end
        ld_words[0] = 16'($urandom);
        start_load();
        stream(1, 1'b1, 20);
        check_release(1);
        foreach (ld_words[k]) if (k < 2) begin end
        for (int k = 0; k < 3; k++) begin
            int a;
            a = (k == 0) ? 60 : (k == 1) ? 0 : 8'($urandom);
            pm_if.cpu_address = 8'(a);
            tick();
            n_cmp++;
            if (pm_if.cpu_data_in !== ref_mem[a]) begin
                n_err++;
                $display("FAIL reload_read: addr %0d got %h expected %h",
                         a, pm_if.cpu_data_in, ref_mem[a]);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) ld_words[i] = 16'($urandom);
        start_load();
        stream(5, 1'b0, 25);
        n_cmp++;
        if (pm_if.ld_count !== 9'd5 || pm_if.ld_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midload_state: got count=%0d ready=%b expected 5/1",
                     pm_if.ld_count, pm_if.ld_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pm_if.cpu_rst_n !== 1'b0 || pm_if.cpu_data_in !== 16'h0 || pm_if.ld_ready !== 1'b0 ||
            pm_if.ld_done !== 1'b0 || pm_if.ld_count !== 9'd0) begin
            n_err++;
            $display("FAIL async_reset: got rst=%b din=%h rdy=%b done=%b cnt=%0d expected all 0",
                     pm_if.cpu_rst_n, pm_if.cpu_data_in, pm_if.ld_ready, pm_if.ld_done, pm_if.ld_count);
        end
        tick();
        tick();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pm_if.ld_valid = 1'($urandom_range(0, 1));
            tick();
            n_cmp++;
            if (pm_if.ld_ready !== 1'b0 || pm_if.cpu_rst_n !== 1'b0 || pm_if.ld_count !== 9'd0) begin
                n_err++;
                $display("FAIL post_reset_hold: cycle %0d got rdy=%b rst=%b cnt=%0d expected 0/0/0",
                         i, pm_if.ld_ready, pm_if.cpu_rst_n, pm_if.ld_count);
            end
        end
        pm_if.ld_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int a = 0; a < 256; a++) ref_mem[a] = 16'h0000;
        test_reset();
        test_basic_load();
        test_read_first();
        test_full_load();
        test_reload();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time limit so a stuck design still reaches the summary line.
    initial begin
        #2000000;
        n_err++;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
